// File: rtl/risc_pkg.sv
// Shared datapath constants: data width, register count, ALU opcodes, flag bit positions.
// No logic of its own; only an immediate-extension helper used by the issue stage.
package risc_pkg;

    localparam int W    = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

    typedef struct packed {
        logic [W-1:0]  in1;
        logic [W-1:0]  in2;
        logic [2:0]    alu_control;
        logic [AW-1:0] rd;
    } ex_entry_t;

    function automatic logic [W-1:0] ext_imm(input logic [15:0] imm, input logic sign_ext);
        return {{(W-16){sign_ext & imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// General register file: two asynchronous read ports, one synchronous write port, R0 reads 0.
// Latency: reads combinational, writes visible through the array the cycle after the edge.
// Backpressure: none; writes are always accepted.
module reg_file_2r1w #(
    parameter int DW = 32,
    parameter int NR = 32,
    parameter int AW = $clog2(NR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] regs [NR];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // R0 is never written, but the read mux forces zero so it does not depend on storage.
    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/operand_issue.sv
// Operand-issue stage: reads rs/rt (with write-back bypass), extends imm, registers ALU operands.
// Latency: 1 cycle from accept to outputs; flags latched 1 cycle after flags_en.
// Backpressure: one-entry output register, issue_ready = !ex_valid || ex_ready.
module operand_issue
    import risc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic [AW-1:0] rd_addr,
    input  logic [15:0]   imm,
    input  logic          use_imm,
    input  logic          sign_ext,
    input  logic [2:0]    alu_op,
    output logic [W-1:0]  in1,
    output logic [W-1:0]  in2,
    output logic [2:0]    alu_control,
    output logic [AW-1:0] ex_rd,
    output logic          ex_valid,
    input  logic          ex_ready,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [W-1:0]  wb_data,
    input  logic          flags_en,
    input  logic          zflag_in,
    input  logic          carryflag_in,
    input  logic          overflowflag_in,
    input  logic          signflag_in,
    output logic [3:0]    flags
);

    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         wb_live;
    logic         accept;
    ex_entry_t    ex_q;
    logic [3:0]   flags_q;

    reg_file_2r1w #(
        .DW(W),
        .NR(NREG),
        .AW(AW)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr_a(rs_addr),
        .rdata_a(rs_data),
        .raddr_b(rt_addr),
        .rdata_b(rt_data),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    // A same-cycle write-back to R0 must not bypass; R0 stays zero.
    assign wb_live = wb_en && (wb_addr != '0);

    always_comb begin
        op1 = rs_data;
        op2 = rt_data;
        if (wb_live && (wb_addr == rs_addr)) begin
            op1 = wb_data;
        end
        if (wb_live && (wb_addr == rt_addr)) begin
            op2 = wb_data;
        end
        if (use_imm) begin
            op2 = ext_imm(imm, sign_ext);
        end
    end

    assign issue_ready = !ex_valid || ex_ready;
    assign accept      = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_q.in1         <= op1;
            ex_q.in2         <= op2;
            ex_q.alu_control <= alu_op;
            ex_q.rd          <= rd_addr;
            ex_valid         <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flags_en) begin
            flags_q[FLAG_Z] <= zflag_in;
            flags_q[FLAG_C] <= carryflag_in;
            flags_q[FLAG_V] <= overflowflag_in;
            flags_q[FLAG_S] <= signflag_in;
        end
    end

    assign in1         = ex_q.in1;
    assign in2         = ex_q.in2;
    assign alu_control = ex_q.alu_control;
    assign ex_rd       = ex_q.rd;
    assign flags       = flags_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: reset, operand read, immediate extension, bypass, stall/drain, flags.
module tb_operand_issue;
    import risc_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic          issue_ready;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] rd_addr;
    logic [15:0]   imm;
    logic          use_imm;
    logic          sign_ext;
    logic [2:0]    alu_op;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic [2:0]    alu_control;
    logic [AW-1:0] ex_rd;
    logic          ex_valid;
    logic          ex_ready;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;
    logic          flags_en;
    logic          zflag_in;
    logic          carryflag_in;
    logic          overflowflag_in;
    logic          signflag_in;
    logic [3:0]    flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_issue dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rd_addr        (rd_addr),
        .imm            (imm),
        .use_imm        (use_imm),
        .sign_ext       (sign_ext),
        .alu_op         (alu_op),
        .in1            (in1),
        .in2            (in2),
        .alu_control    (alu_control),
        .ex_rd          (ex_rd),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .flags_en       (flags_en),
        .zflag_in       (zflag_in),
        .carryflag_in   (carryflag_in),
        .overflowflag_in(overflowflag_in),
        .signflag_in    (signflag_in),
        .flags          (flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic [15:0] im, input logic ui, input logic se, input logic [2:0] op);
        issue_valid = 1'b1;
        rs_addr     = rs;
        rt_addr     = rt;
        rd_addr     = rd;
        imm         = im;
        use_imm     = ui;
        sign_ext    = se;
        alu_op      = op;
    endtask

    task automatic wb(input logic en, input logic [AW-1:0] a, input logic [W-1:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; rs_addr = '0; rt_addr = '0; rd_addr = '0;
        imm = '0; use_imm = 1'b0; sign_ext = 1'b0; alu_op = '0;
        ex_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flags_en = 1'b0; zflag_in = 1'b0; carryflag_in = 1'b0;
        overflowflag_in = 1'b0; signflag_in = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_in1", in1, 32'd0);

        // Registers read as zero after reset.
        issue(5'd7, 5'd9, 5'd0, 16'd0, 1'b0, 1'b0, ALU_ADD);
        step();
        chk("rst_r7", in1, 32'd0);
        chk("rst_r9", in2, 32'd0);
        issue_valid = 1'b0;

        wb(1'b1, 5'd1, 32'd43); step();
        wb(1'b1, 5'd2, 32'd5);  step();
        wb(1'b1, 5'd3, 32'd4);  step();
        wb(1'b0, 5'd0, 32'd0);

        issue(5'd1, 5'd2, 5'd6, 16'd0, 1'b0, 1'b0, ALU_ADD);
        step();
        chk("rr_in1", in1, 32'd43);
        chk("rr_in2", in2, 32'd5);
        chk("rr_ctl", {29'd0, alu_control}, 32'd0);
        chk("rr_valid", {31'd0, ex_valid}, 32'd1);
        chk("rr_rd", {27'd0, ex_rd}, 32'd6);

        issue(5'd3, 5'd2, 5'd7, 16'hFFFE, 1'b1, 1'b1, ALU_XOR);
        step();
        chk("sx_in1", in1, 32'd4);
        chk("sx_in2", in2, 32'hFFFF_FFFE);
        chk("sx_ctl", {29'd0, alu_control}, 32'd4);
        sign_ext = 1'b0;
        step();
        chk("zx_in2", in2, 32'h0000_FFFE);

        // Write-back and issue in the same cycle: bypass on both operands.
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        issue(5'd5, 5'd5, 5'd8, 16'd0, 1'b0, 1'b0, ALU_SUB);
        step();
        chk("byp_in1", in1, 32'hDEAD_BEEF);
        chk("byp_in2", in2, 32'hDEAD_BEEF);
        wb(1'b1, 5'd0, 32'd7);
        issue(5'd0, 5'd0, 5'd8, 16'd0, 1'b0, 1'b0, ALU_SUB);
        step();
        chk("byp_r0_in1", in1, 32'd0);
        chk("byp_r0_in2", in2, 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        issue(5'd5, 5'd1, 5'd9, 16'd0, 1'b0, 1'b0, ALU_AND);
        step();
        chk("arr_r5", in1, 32'hDEAD_BEEF);
        chk("arr_r1", in2, 32'd43);

        // Stall: entry valid, downstream not ready.
        ex_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd10, 16'd0, 1'b0, 1'b0, ALU_OR);
        #1;
        chk("stall_rdy0", {31'd0, issue_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in1", in1, 32'hDEAD_BEEF);
            chk("stall_rd", {27'd0, ex_rd}, 32'd9);
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
            chk("stall_rdy", {31'd0, issue_ready}, 32'd0);
        end
        ex_ready = 1'b1;
        #1;
        chk("rel_rdy", {31'd0, issue_ready}, 32'd1);
        step();
        chk("rel_in1", in1, 32'd43);
        chk("rel_in2", in2, 32'd5);
        chk("rel_ctl", {29'd0, alu_control}, 32'd3);

        // Drain without a new issue.
        issue_valid = 1'b0;
        step();
        chk("drain_valid", {31'd0, ex_valid}, 32'd0);
        chk("drain_hold", in1, 32'd43);

        flags_en = 1'b1; zflag_in = 1'b1; carryflag_in = 1'b0;
        overflowflag_in = 1'b1; signflag_in = 1'b0;
        step();
        chk("flags_set", {28'd0, flags}, 32'b1010);
        flags_en = 1'b0; zflag_in = 1'b0; carryflag_in = 1'b1; signflag_in = 1'b1;
        step();
        chk("flags_hold", {28'd0, flags}, 32'b1010);

        // Reset with a valid entry and a simultaneous write-back.
        issue(5'd2, 5'd1, 5'd11, 16'd0, 1'b0, 1'b0, ALU_SLT);
        step();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        issue_valid = 1'b0;
        rst = 1'b1;
        wb(1'b1, 5'd4, 32'd99);
        step();
        rst = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        chk("mrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mrst_flags", {28'd0, flags}, 32'd0);
        chk("mrst_rdy", {31'd0, issue_ready}, 32'd1);
        chk("mrst_in1", in1, 32'd0);
        issue(5'd4, 5'd1, 5'd0, 16'd0, 1'b0, 1'b0, ALU_ADD);
        step();
        chk("mrst_r4", in1, 32'd0);
        chk("mrst_r1", in2, 32'd0);
        issue_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
# operand_issue

Register-file and operand-issue stage sitting directly upstream of the `alu`. It holds the 32×32 general register file, reads two source operands per instruction, and optionally substitutes an extended 16-bit immediate for the second operand. It presents `in1`/`in2`/`alu_control` to the ALU from a one-entry output register with a valid/ready handshake. It also accepts the write-back of ALU results and latches the ALU status flags into a flag register.

## Interface
- `W`, 32, data width (matches ALU `in1`/`in2`/`out`)
- `NREG`, 32, number of registers; address width is log2(NREG) = 5
- `clk` input 1 system clock, rising edge
- `rst` input 1 synchronous, active-high reset
- `issue_valid` input 1 decoded instruction available
- `issue_ready` output 1 stage can accept an instruction this cycle
- `rs_addr` input 5 first source register
- `rt_addr` input 5 second source register
- `rd_addr` input 5 destination register, carried alongside
- `imm` input 16 immediate field
- `use_imm` input 1 1 = `in2` comes from `imm`, not `rt`
- `sign_ext` input 1 1 = sign-extend `imm`, 0 = zero-extend
- `alu_op` input 3 ALU operation code
- `in1` output W first ALU operand (registered)
- `in2` output W second ALU operand (registered)
- `alu_control` output 3 ALU operation (registered)
- `ex_rd` output 5 destination register of the issued entry
- `ex_valid` output 1 output register holds a valid entry
- `ex_ready` input 1 downstream consumes the entry this cycle
- `wb_en` input 1 write `wb_data` into `wb_addr`
- `wb_addr` input 5 write-back register
- `wb_data` input W write-back value (ALU `out`)
- `flags_en` input 1 latch the flag inputs
- `zflag_in`, `carryflag_in`, `overflowflag_in`, `signflag_in` input 1 each ALU status flags
- `flags` output 4 latched {z, c, v, s}

## Operation
- Register 0 always reads 0. Writes to register 0 are ignored.
- Accept condition: `issue_valid && issue_ready`.
- `issue_ready = !ex_valid || ex_ready`. This is combinational and allows back-to-back issue while the downstream stage drains.
- On accept, operands are computed from the current read values and captured into the output register:
  - `in1` = R[rs_addr].
  - `in2` = `use_imm` ? ext(imm) : R[rt_addr].
  - `alu_control` = `alu_op`.
  - `ex_rd` = `rd_addr`.
  - `ex_valid` ← 1.
- Sign extension replicates `imm[15]` into bits 31:16. Zero extension fills bits 31:16 with 0.
- Write-back bypass: when `wb_en`, `wb_addr != 0`, and `wb_addr` matches `rs_addr` (or `rt_addr` with `use_imm` = 0) in the accept cycle, the operand takes `wb_data` instead of the stale register value.
- Write-back and issue are independent. Both can occur in the same cycle.
- Drain without a new issue: when `ex_ready && ex_valid && !accept`, `ex_valid` ← 0. The operand outputs hold their last values.
- Stall: when `ex_valid && !ex_ready`, all outputs hold and `issue_ready` = 0.
- `flags` ← {`zflag_in`, `carryflag_in`, `overflowflag_in`, `signflag_in`} when `flags_en` is high. Otherwise `flags` holds.

## Timing
- Issue latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N.
- Write-back latency: `wb_data` is readable through the array from the cycle after edge N. It is visible in the same cycle through the bypass.
- Reset (synchronous, `rst` = 1 at a rising edge), all to 0:
  - all registers;
  - `in1`, `in2`, `alu_control`, `ex_rd`, `ex_valid`, `flags`.
- Reset mid-operation: any pending entry is discarded. `issue_ready` = 1 in the first cycle after reset.
- Conflicting same-cycle events:
  - When `wb_en` and `rst` are both high, reset wins.
  - When a write-back targets register 0, the bypass is suppressed and the operand reads 0.

## Structure
- The shared package `risc_pkg` holds:
  - the ALU opcode constants (3-bit `alu_control` encodings, e.g. ADD = 3'd0);
  - `W`, `NREG`;
  - the flag bit positions (Z = 3, C = 2, V = 1, S = 0).
- Sub-module `reg_file_2r1w`: two asynchronous read ports, one synchronous write port, register 0 hardwired to 0. Bypass muxing, immediate extension, the handshake register, and the flag register stay in `operand_issue`.

## Test plan
- After reset: `ex_valid` = 0, `issue_ready` = 1, `flags` = 0, and reading any register returns 0.
- Write R1 = 43, R2 = 5, then issue rs = 1, rt = 2, `use_imm` = 0, `alu_op` = 0. Next cycle: `in1` = 43, `in2` = 5, `alu_control` = 0, `ex_valid` = 1.
- Immediate extension, with R3 = 4:
  - issue rs = 3, `imm` = 16'hFFFE, `use_imm` = 1, `sign_ext` = 1, `alu_op` = 4 → `in1` = 4, `in2` = 32'hFFFFFFFE;
  - same with `sign_ext` = 0 → `in2` = 32'h0000FFFE.
- Bypass: in one cycle, write R5 = 32'hDEADBEEF and issue rs = 5. Expect `in1` = 32'hDEADBEEF. Then write R0 = 7 and issue rs = 0. Expect `in1` = 0.
- Stall/drain:
  - hold `ex_ready` = 0 with an entry valid for 3 cycles → outputs stable, `issue_ready` = 0;
  - raise `ex_ready` with `issue_valid` = 1 → the new entry loads the next cycle.
- Flags and reset: `flags_en` with z = 1, c = 0, v = 1, s = 0 → `flags` = 4'b1010. Then assert `rst` while an entry is valid → `ex_valid` = 0 and `flags` = 0 the next cycle.
